// File: rtl/uart_image_loader.sv
// ----------------------------------------------------------------------------
// uart_image_loader
//
// Receives 8N1 UART bytes from a host PC and writes them, in arrival order, as
// 8-bit grayscale pixels into the write port of the image memory. A load is
// armed by a one-cycle start pulse and completes after IMAGE_SIZE good bytes.
//
// Parameters
//   CLK_FREQ    clock frequency in Hz
//   BAUD        UART bit rate; CPB = CLK_FREQ / BAUD clocks per bit
//   ADDR_WIDTH  pixel address width (matches the image memory)
//   IMAGE_SIZE  pixels per image
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   start_i      one-cycle pulse that arms a new image load
//   rx_i         UART serial input, idle high, asynchronous to clk_i
//   wr_en_o      one-cycle image memory write strobe
//   wr_addr_o    pixel address, valid with wr_en_o (held between strobes)
//   wr_data_o    pixel byte, valid with wr_en_o (held between strobes)
//   busy_o       high while a load is in progress
//   done_o       sticky: IMAGE_SIZE bytes have been written
//   frame_err_o  sticky: a byte with a bad stop bit arrived during this load
// ----------------------------------------------------------------------------
module uart_image_loader #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 18,
    parameter int IMAGE_SIZE = 65536
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  rx_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [7:0]            wr_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  frame_err_o
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int TW  = (CPB > 1) ? $clog2(CPB + 1) : 1;

    localparam logic [TW-1:0]         BIT_LAST  = TW'(CPB - 1);
    localparam logic [TW-1:0]         HALF_LAST = TW'(CPB / 2 - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX  = ADDR_WIDTH'(IMAGE_SIZE - 1);

    // ------------------------------------------------------------------
    // rx synchronizer. A third stage keeps the previous synchronized value
    // so the idle state can look for a genuine falling edge; a line that
    // is still low after a bad stop bit must not retrigger a frame.
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t     rx_state_q;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;

    logic bit_tick;
    logic stop_tick;
    logic byte_valid;
    logic stop_bad;

    assign timer_d   = timer_q + 1'b1;
    assign bit_tick  = (timer_q == BIT_LAST);
    assign stop_tick = (rx_state_q == RX_STOP) && bit_tick;

    // Byte outcome is decoded in the stop-sample cycle itself so the loader
    // can register the write strobe on that same edge.
    assign byte_valid = stop_tick &&  rx_s_q;
    assign stop_bad   = stop_tick && !rx_s_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state_q <= RX_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    timer_q <= '0;
                    if (rx_prev_q && !rx_s_q) begin
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (timer_q == HALF_LAST) begin
                        timer_q   <= '0;
                        bit_idx_q <= '0;
                        // Line back high at mid start bit: treat as noise.
                        rx_state_q <= rx_s_q ? RX_IDLE : RX_DATA;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                RX_DATA: begin
                    if (bit_tick) begin
                        timer_q <= '0;
                        // LSB arrives first, so shift in from the top.
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                RX_STOP: begin
                    if (bit_tick) begin
                        timer_q    <= '0;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                default: begin
                    rx_state_q <= RX_IDLE;
                    timer_q    <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM with registered outputs
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_DONE
    } ld_state_t;

    ld_state_t             ld_state_q;
    logic [ADDR_WIDTH-1:0] counter_q;
    logic [ADDR_WIDTH-1:0] counter_d;
    logic                  last_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [7:0]            wr_data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  frame_err_q;

    assign counter_d = counter_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_state_q  <= LD_IDLE;
            counter_q   <= '0;
            last_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (ld_state_q)
                LD_IDLE, LD_DONE: begin
                    if (start_i) begin
                        ld_state_q  <= LD_LOAD;
                        counter_q   <= '0;
                        last_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        frame_err_q <= 1'b0;
                    end
                end
                LD_LOAD: begin
                    if (last_q) begin
                        // Final pixel was strobed last cycle; finish now.
                        ld_state_q <= LD_DONE;
                        last_q     <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        if (byte_valid) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= counter_q;
                            wr_data_q <= shift_q;
                            // Counter parks on the last pixel instead of wrapping.
                            if (counter_q == LAST_PIX) begin
                                last_q <= 1'b1;
                            end else begin
                                counter_q <= counter_d;
                            end
                        end
                        if (stop_bad) begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    ld_state_q <= LD_IDLE;
                end
            endcase
        end
    end

    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign frame_err_o = frame_err_q;

endmodule
